// File: rtl/queue_header_stripper.sv
// queue_header_stripper: removes the queue-ID header from AXIS packets, realigns the payload and emits ID/length sideband
module queue_header_stripper #(
  parameter int AXIS_DATA_WIDTH   = 64,
  parameter int QUEUE_ID_WIDTH    = 32,
  parameter int PACKET_SIZE_WIDTH = 11,
  parameter int NUM_QUEUES        = 1024,
  parameter int ID_BIG_ENDIAN     = 1,
  parameter int DROP_INVALID      = 1,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  output logic                           s_axis_tready_o,
  input  logic                           s_axis_tvalid_i,
  input  logic [AXIS_DATA_WIDTH-1:0]     s_axis_tdata_i,
  input  logic [AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep_i,
  input  logic                           s_axis_tlast_i,
  input  logic [PACKET_SIZE_WIDTH-1:0]   s_axis_packet_length_i,
  input  logic                           m_axis_tready_i,
  output logic                           m_axis_tvalid_o,
  output logic [AXIS_DATA_WIDTH-1:0]     m_axis_tdata_o,
  output logic [AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep_o,
  output logic                           m_axis_tlast_o,
  output logic [PACKET_SIZE_WIDTH-1:0]   m_axis_packet_length_o,
  output logic [QUEUE_ID_WIDTH-1:0]      m_queue_id_o,
  output logic                           m_queue_err_o,
  output logic [CNT_WIDTH-1:0]           drop_cnt_o,
  output logic [CNT_WIDTH-1:0]           runt_cnt_o
);
  localparam int B   = AXIS_DATA_WIDTH / 8;
  localparam int H   = QUEUE_ID_WIDTH / 8;
  localparam int HDW = AXIS_DATA_WIDTH - QUEUE_ID_WIDTH;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] DROP   = 2'd3;
  localparam logic [QUEUE_ID_WIDTH:0]      ID_LIMIT = (QUEUE_ID_WIDTH+1)'(NUM_QUEUES);
  localparam logic [PACKET_SIZE_WIDTH-1:0] HDR_LEN  = PACKET_SIZE_WIDTH'(H);

  logic [1:0]                   state_q, state_d;
  logic [HDW-1:0]               hold_data_q, hold_data_d;
  logic [B-H-1:0]               hold_keep_q, hold_keep_d;
  logic [QUEUE_ID_WIDTH-1:0]    queue_id_q, queue_id_d, hdr_id;
  logic [PACKET_SIZE_WIDTH-1:0] pkt_len_q, pkt_len_d;
  logic                         queue_err_q, queue_err_d;
  logic [CNT_WIDTH-1:0]         drop_cnt_q, drop_cnt_d, runt_cnt_q, runt_cnt_d;
  logic                         s_fire, upper_empty, runt, id_invalid, in_flush;

  // Extract the header ID, swapping bytes when byte 0 carries the MSB
  always_comb begin
    hdr_id = s_axis_tdata_i[QUEUE_ID_WIDTH-1:0];
    if (ID_BIG_ENDIAN != 0)
      for (int i = 0; i < H; i++) hdr_id[i*8 +: 8] = s_axis_tdata_i[(H-1-i)*8 +: 8];
  end

  assign in_flush        = state_q == FLUSH;
  assign upper_empty     = ~|s_axis_tkeep_i[B-1:H];
  assign runt            = ~&s_axis_tkeep_i[H-1:0] || (s_axis_tlast_i && upper_empty);
  assign id_invalid      = {1'b0, hdr_id} >= ID_LIMIT;
  assign s_axis_tready_o = state_q == STREAM ? m_axis_tready_i : !in_flush;
  assign s_fire          = s_axis_tvalid_i && s_axis_tready_o;
  assign m_axis_tvalid_o = state_q == STREAM ? s_axis_tvalid_i : in_flush;
  assign m_axis_tlast_o  = state_q == STREAM ? s_axis_tlast_i && upper_empty : in_flush;
  assign m_axis_tdata_o  = {in_flush ? {QUEUE_ID_WIDTH{1'b0}} : s_axis_tdata_i[QUEUE_ID_WIDTH-1:0], hold_data_q};
  assign m_axis_tkeep_o  = {in_flush ? {H{1'b0}} : s_axis_tkeep_i[H-1:0], hold_keep_q};
  assign m_axis_packet_length_o = pkt_len_q;
  assign m_queue_id_o    = queue_id_q;
  assign m_queue_err_o   = queue_err_q;
  assign drop_cnt_o      = drop_cnt_q;
  assign runt_cnt_o      = runt_cnt_q;

  // Packet sequencing: classify the first beat, stream realigned beats, flush the tail, or discard
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    queue_id_d  = queue_id_q;
    pkt_len_d   = pkt_len_q;
    queue_err_d = queue_err_q;
    drop_cnt_d  = drop_cnt_q;
    runt_cnt_d  = runt_cnt_q;
    if (state_q == IDLE && s_fire) begin
      queue_id_d  = hdr_id;
      pkt_len_d   = s_axis_packet_length_i - HDR_LEN;
      queue_err_d = id_invalid && DROP_INVALID == 0;
      hold_data_d = s_axis_tdata_i[AXIS_DATA_WIDTH-1:QUEUE_ID_WIDTH];
      hold_keep_d = s_axis_tkeep_i[B-1:H];
      if (runt) begin
        runt_cnt_d = runt_cnt_q + 1'b1;
        state_d    = s_axis_tlast_i ? IDLE : DROP;
      end else if (id_invalid && DROP_INVALID != 0) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
        state_d    = s_axis_tlast_i ? IDLE : DROP;
      end else begin
        state_d = s_axis_tlast_i ? FLUSH : STREAM;
      end
    end
    if (state_q == STREAM && s_fire) begin
      hold_data_d = s_axis_tdata_i[AXIS_DATA_WIDTH-1:QUEUE_ID_WIDTH];
      hold_keep_d = s_axis_tkeep_i[B-1:H];
      if (s_axis_tlast_i) state_d = upper_empty ? IDLE : FLUSH;
    end
    if (in_flush && m_axis_tready_i) state_d = IDLE;
    if (state_q == DROP && s_fire && s_axis_tlast_i) state_d = IDLE;
  end

  // State, held tail bytes, sideband and counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_keep_q <= '0;
      queue_id_q  <= '0;
      pkt_len_q   <= '0;
      queue_err_q <= 1'b0;
      drop_cnt_q  <= '0;
      runt_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      queue_id_q  <= queue_id_d;
      pkt_len_q   <= pkt_len_d;
      queue_err_q <= queue_err_d;
      drop_cnt_q  <= drop_cnt_d;
      runt_cnt_q  <= runt_cnt_d;
    end
  end
endmodule

// File: tb/tb_queue_header_stripper.sv
// tb_queue_header_stripper: directed and randomised-backpressure checks of header stripping, drops and reset
module tb_queue_header_stripper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic rnd = 1'b0;
  logic s_tvalid = 1'b0;
  logic [63:0] s_tdata = '0;
  logic [7:0] s_tkeep = '0;
  logic s_tlast = 1'b0;
  logic [10:0] s_len = '0;
  logic m_tready = 1'b1;
  logic s_tready_a, s_tready_b, m_tvalid_a, m_tvalid_b, m_tlast_a, m_tlast_b, m_err_a, m_err_b;
  logic [63:0] m_tdata_a, m_tdata_b;
  logic [7:0] m_tkeep_a, m_tkeep_b;
  logic [10:0] m_len_a, m_len_b;
  logic [31:0] m_id_a, m_id_b, drop_a, drop_b, runt_a, runt_b;
  logic s_tready, m_tvalid, m_tlast, m_err;
  logic [63:0] m_tdata;
  logic [7:0] m_tkeep;
  logic [10:0] m_len;
  logic [31:0] m_id;

  typedef struct packed {
    logic [31:0] id;
    logic [10:0] len;
    logic        err;
    logic [7:0]  beats;
    logic [7:0]  last_keep;
    logic        tready_last;
  } pkt_t;

  pkt_t got_pkts[$];
  logic [7:0] got_bytes[$];
  logic [7:0] exp_bytes[$];
  logic [42:0] exp_pkts[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign s_tready = sel ? s_tready_b : s_tready_a;
  assign m_tvalid = sel ? m_tvalid_b : m_tvalid_a;
  assign m_tlast  = sel ? m_tlast_b  : m_tlast_a;
  assign m_err    = sel ? m_err_b    : m_err_a;
  assign m_tdata  = sel ? m_tdata_b  : m_tdata_a;
  assign m_tkeep  = sel ? m_tkeep_b  : m_tkeep_a;
  assign m_len    = sel ? m_len_b    : m_len_a;
  assign m_id     = sel ? m_id_b     : m_id_a;

  queue_header_stripper dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .s_axis_tready_o(s_tready_a), .s_axis_tvalid_i(s_tvalid && !sel), .s_axis_tdata_i(s_tdata),
    .s_axis_tkeep_i(s_tkeep), .s_axis_tlast_i(s_tlast), .s_axis_packet_length_i(s_len),
    .m_axis_tready_i(m_tready), .m_axis_tvalid_o(m_tvalid_a), .m_axis_tdata_o(m_tdata_a),
    .m_axis_tkeep_o(m_tkeep_a), .m_axis_tlast_o(m_tlast_a), .m_axis_packet_length_o(m_len_a),
    .m_queue_id_o(m_id_a), .m_queue_err_o(m_err_a), .drop_cnt_o(drop_a), .runt_cnt_o(runt_a)
  );

  queue_header_stripper #(.DROP_INVALID(0)) dut_fwd (
    .clk_i(clk), .rst_n_i(rst_n),
    .s_axis_tready_o(s_tready_b), .s_axis_tvalid_i(s_tvalid && sel), .s_axis_tdata_i(s_tdata),
    .s_axis_tkeep_i(s_tkeep), .s_axis_tlast_i(s_tlast), .s_axis_packet_length_i(s_len),
    .m_axis_tready_i(m_tready), .m_axis_tvalid_o(m_tvalid_b), .m_axis_tdata_o(m_tdata_b),
    .m_axis_tkeep_o(m_tkeep_b), .m_axis_tlast_o(m_tlast_b), .m_axis_packet_length_o(m_len_b),
    .m_queue_id_o(m_id_b), .m_queue_err_o(m_err_b), .drop_cnt_o(drop_b), .runt_cnt_o(runt_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // output monitor: collects bytes and per-packet sideband, checks sideband stability within a packet
  initial begin
    logic [31:0] cid;
    logic [10:0] clen;
    logic cerr;
    logic [7:0] cbeats;
    cbeats = 0; cid = 0; clen = 0; cerr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) cbeats = 0;
      else if (m_tvalid && m_tready) begin
        if (cbeats == 0) begin
          cid = m_id; clen = m_len; cerr = m_err;
        end else begin
          check("sb_id", m_id, cid);
          check("sb_len", m_len, clen);
          check("sb_err", m_err, cerr);
        end
        for (int i = 0; i < 8; i++) if (m_tkeep[i]) got_bytes.push_back(m_tdata[i*8 +: 8]);
        cbeats++;
        if (m_tlast) begin
          got_pkts.push_back('{cid, clen, cerr, cbeats, m_tkeep, s_tready});
          cbeats = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd) m_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [10:0] n);
    int t;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_len = n; s_tvalid = 1'b1;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_tready) break;
    end
    if (t == 200) check("in_timeout", 1, 0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] id, input int npay, input logic fwd);
    logic [7:0] b[$];
    logic [63:0] d;
    logic [7:0] k;
    int n, nb;
    for (int i = 0; i < 4; i++) b.push_back(id[(3-i)*8 +: 8]);
    for (int i = 0; i < npay; i++) begin
      b.push_back(8'($urandom));
      if (fwd) exp_bytes.push_back(b[4+i]);
    end
    n = 4 + npay;
    nb = (n + 7) / 8;
    for (int j = 0; j < nb; j++) begin
      d = '0; k = '0;
      for (int i = 0; i < 8; i++) if (j*8 + i < n) begin
        d[i*8 +: 8] = b[j*8 + i];
        k[i] = 1'b1;
      end
      send_beat(d, k, j == nb - 1, 11'(n));
    end
  endtask

  task automatic wait_pkts(input int n);
    int t;
    for (t = 0; t < 5000; t++) begin
      if (got_pkts.size() >= n) break;
      @(posedge clk);
    end
    if (t == 5000) check("out_timeout", 64'(got_pkts.size()), 64'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag);
    int bad;
    bad = 0;
    check({tag, "_nbytes"}, 64'(got_bytes.size()), 64'(exp_bytes.size()));
    for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
      if (got_bytes[i] !== exp_bytes[i]) bad++;
    check({tag, "_bytes_bad"}, 64'(bad), 0);
    got_bytes.delete();
    exp_bytes.delete();
  endtask

  initial begin
    pkt_t p;
    logic [31:0] rid;
    int rn;
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_id", m_id, 0);
    check("rst_len", m_len, 0);
    check("rst_err", m_err, 0);
    check("rst_drop", drop_a, 0);
    check("rst_runt", runt_a, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_tready", s_tready, 1);
    @(posedge clk);
    #1;

    send_pkt(32'h12A, 16, 1'b1);
    wait_pkts(1);
    p = got_pkts.pop_front();
    check("t1_id", p.id, 32'h12A);
    check("t1_len", p.len, 16);
    check("t1_err", p.err, 0);
    check("t1_beats", p.beats, 2);
    check("t1_last_keep", p.last_keep, 8'hFF);
    check("t1_no_flush", p.tready_last, 1);
    check_stream("t1");

    send_pkt(32'd7, 12, 1'b1);
    wait_pkts(1);
    p = got_pkts.pop_front();
    check("t2_len", p.len, 12);
    check("t2_beats", p.beats, 2);
    check("t2_flush_keep", p.last_keep, 8'h0F);
    check("t2_flush_tready", p.tready_last, 0);
    check_stream("t2");

    send_beat(64'h0000_0000_0500_0000, 8'h0F, 1'b1, 11'd4);
    repeat (4) @(posedge clk);
    #1;
    check("runt_cnt", runt_a, 1);
    check("runt_drop_cnt", drop_a, 0);
    check("runt_no_out", 64'(got_pkts.size()), 0);

    send_pkt(32'd1024, 8, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("inv_drop_cnt", drop_a, 1);
    check("inv_runt_cnt", runt_a, 1);
    check("inv_no_out", 64'(got_pkts.size()), 0);
    check("inv_consumed", s_tready, 1);
    check_stream("inv");

    send_pkt(32'd5, 3, 1'b1);
    wait_pkts(1);
    p = got_pkts.pop_front();
    check("t4_id", p.id, 5);
    check("t4_len", p.len, 3);
    check("t4_beats", p.beats, 1);
    check("t4_keep", p.last_keep, 8'h07);
    check_stream("t4");

    sel = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(32'd1024, 16, 1'b1);
    wait_pkts(1);
    p = got_pkts.pop_front();
    check("fwd_id", p.id, 1024);
    check("fwd_err", p.err, 1);
    check("fwd_len", p.len, 16);
    check("fwd_beats", p.beats, 2);
    check("fwd_drop_cnt", drop_b, 0);
    check_stream("fwd");
    sel = 1'b0;
    @(posedge clk);
    #1;

    rnd = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rid = 32'($urandom_range(0, 1023));
      rn = $urandom_range(1, 40);
      exp_pkts.push_back({rid, 11'(rn)});
      send_pkt(rid, rn, 1'b1);
    end
    wait_pkts(100);
    check("rnd_npkts", 64'(got_pkts.size()), 100);
    while (got_pkts.size() > 0 && exp_pkts.size() > 0) begin
      p = got_pkts.pop_front();
      check("rnd_id", p.id, 64'(exp_pkts[0][42:11]));
      check("rnd_len", p.len, 64'(exp_pkts[0][10:0]));
      check("rnd_err", p.err, 0);
      void'(exp_pkts.pop_front());
    end
    check_stream("rnd");
    rnd = 1'b0;
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    got_pkts.delete();

    send_beat(64'h1111_1111_0900_0000, 8'hFF, 1'b0, 11'd28);
    send_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0, 11'd28);
    s_tdata = 64'h3333_3333_3333_3333; s_tkeep = 8'hFF; s_tlast = 1'b0; s_tvalid = 1'b1;
    @(negedge clk);
    check("pre_rst_tvalid", m_tvalid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_tlast", m_tlast, 0);
    check("mid_rst_drop", drop_a, 0);
    check("mid_rst_runt", runt_a, 0);
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_pkts.delete();
    got_bytes.delete();
    exp_bytes.delete();
    @(posedge clk);
    #1;
    check("post_rst_no_out", 64'(got_pkts.size()), 0);
    send_pkt(32'd9, 20, 1'b1);
    wait_pkts(1);
    p = got_pkts.pop_front();
    check("post_rst_id", p.id, 9);
    check("post_rst_len", p.len, 20);
    check("post_rst_beats", p.beats, 3);
    check("post_rst_keep", p.last_keep, 8'h0F);
    check_stream("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/queue_header_stripper.md
# queue_header_stripper

Parametrised successor to the queue-ID cutter, sitting between the packet classifier and the queue manager. It removes a QUEUE_ID_WIDTH-bit queue-ID header from the front of each AXI-Stream packet and re-aligns the payload. It presents the decoded queue ID and the corrected packet length as per-packet sideband. Unlike the previous generation, it handles selectable ID endianness, range-checks the ID against NUM_QUEUES, discards invalid and runt packets with counters, and obeys strict AXIS backpressure in every state.

## Interface
- AXIS_DATA_WIDTH, 64: data bus width; multiple of 8.
- QUEUE_ID_WIDTH, 32: header width; multiple of 8 and less than AXIS_DATA_WIDTH.
- PACKET_SIZE_WIDTH, 11: packet length field width, in bytes.
- NUM_QUEUES, 1024: IDs greater than or equal to this value are invalid.
- ID_BIG_ENDIAN, 1: 1 means header byte 0 is the ID's MSB (byte-swapped on extraction); 0 means byte 0 is the LSB.
- DROP_INVALID, 1: 1 discards invalid-ID packets; 0 forwards them with m_queue_err_o=1.
- CNT_WIDTH, 32: statistics counter width.
- clk_i  in  1  clock; one clock domain.
- rst_n_i  in  1  asynchronous, active-low reset.
- s_axis_tready_o / s_axis_tvalid_i / s_axis_tdata_i / s_axis_tkeep_i / s_axis_tlast_i  out/in/in/in/in  1/1/AXIS_DATA_WIDTH/AXIS_DATA_WIDTH/8/1  input stream; byte 0 is bits [7:0].
- s_axis_packet_length_i  in  PACKET_SIZE_WIDTH  packet length including header; sampled on the first beat.
- m_axis_tready_i / m_axis_tvalid_o / m_axis_tdata_o / m_axis_tkeep_o / m_axis_tlast_o  in/out/out/out/out  same widths  output stream, with the header removed.
- m_axis_packet_length_o  out  PACKET_SIZE_WIDTH  input length minus QUEUE_ID_WIDTH/8.
- m_queue_id_o  out  QUEUE_ID_WIDTH  decoded queue ID.
- m_queue_err_o  out  1  ID out of range; only asserted when DROP_INVALID=0.
- drop_cnt_o  out  CNT_WIDTH  count of packets discarded for an invalid ID; wraps.
- runt_cnt_o  out  CNT_WIDTH  count of packets discarded as runts; wraps.

## Operation
- Notation: B = AXIS_DATA_WIDTH/8; H = QUEUE_ID_WIDTH/8.
- Held registers: hold_data stores the upper B-H bytes of the previous beat; hold_keep stores their keep bits.
- Output beat layout:
  - m_axis_tdata_o = {s_axis_tdata_i low H bytes, hold_data}
  - m_axis_tkeep_o = {s_axis_tkeep_i low H bits, hold_keep}
- IDLE (s_axis_tready_o=1, m_axis_tvalid_o=0). On accepting the first beat:
  - Latch the ID (byte-swapped if ID_BIG_ENDIAN=1), the length minus H, hold_data and hold_keep.
  - Runt: the header keep bits are not all 1, or the beat has tlast with upper keep equal to 0. Increment runt_cnt_o and go to DROP, or stay in IDLE if tlast is set.
  - Invalid ID with DROP_INVALID=1: increment drop_cnt_o and go to DROP, or stay in IDLE if tlast is set.
  - First beat with tlast and nonzero upper keep: go to FLUSH.
  - Otherwise: go to STREAM.
- STREAM:
  - m_axis_tvalid_o = s_axis_tvalid_i; s_axis_tready_o = m_axis_tready_i.
  - m_axis_tlast_o = s_axis_tlast_i && (upper keep == 0).
  - On a transfer, reload hold_data and hold_keep.
  - On tlast: go to IDLE if upper keep == 0, else go to FLUSH.
- FLUSH:
  - s_axis_tready_o=0; m_axis_tvalid_o=1; m_axis_tlast_o=1.
  - Output data = {0, hold_data}; output keep = {0, hold_keep}.
  - On m_axis_tready_i, go to IDLE.
- DROP: s_axis_tready_o=1; m_axis_tvalid_o=0; consume beats until tlast, then go to IDLE.
- Sideband (ID, length, err) holds from the first output beat through the tlast handshake and changes only in IDLE.
- Once asserted, m_axis_tvalid_o and the output data are never retracted without a handshake, provided the upstream also obeys AXIS.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State is IDLE; all held registers, sideband outputs and counters are 0.
  - m_axis_tvalid_o=0 and m_axis_tlast_o=0; s_axis_tready_o=1 after reset releases.
- Latency:
  - Output beat k is combinational with input beat k+1.
  - The first input beat produces no output.
  - FLUSH costs exactly one cycle after the last input beat when downstream is ready.
  - There is one input bubble per packet that requires FLUSH.
- Throughput: one beat per cycle in STREAM.
- Reset mid-packet: the partial packet is lost, no tlast is emitted, and counters clear.
- Counters increment once per discarded packet, on the first beat, and wrap at 2^CNT_WIDTH.
- Backpressure in FLUSH: the state holds and the outputs stay stable.

## Test plan
- 3-beat packet (64-bit bus, keep FF/FF/0F), ID bytes 00 00 01 2A, length 20:
  - Expect m_queue_id_o=0x12A, length 16.
  - Expect 2 output beats with keep FF/FF, the second with tlast, and no FLUSH.
- 2-beat packet with keep FF/FF:
  - Expect a FLUSH beat with keep 0F and tlast, and s_axis_tready_o=0 for that cycle.
- Single beat with keep 0F and tlast: expect no output and runt_cnt_o=1.
  - Then ID 1024 (2 beats): expect no output, drop_cnt_o=1, and input fully consumed.
- Same invalid packet with DROP_INVALID=0: expect it forwarded with m_queue_err_o=1 held through tlast.
- Random m_axis_tready_i (50%) over 100 random-length packets: expect the output byte stream to equal the input with headers removed and every ID/length correct.
- rst_n_i pulsed low mid-STREAM: expect m_axis_tvalid_o=0 immediately, counters 0, and the next packet processed correctly.
